// File: rtl/videocard_pkg.sv
// Shared constants for the videocard launch controller: register map, bit fields, FSM encoding.
package videocard_pkg;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_STATUS    = 3'd1;
    localparam logic [2:0] ADDR_ENTRY_PC  = 3'd2;
    localparam logic [2:0] ADDR_CORE_MASK = 3'd3;
    localparam logic [2:0] ADDR_CYCLES    = 3'd4;
    localparam logic [2:0] ADDR_TIMEOUT   = 3'd5;
    localparam logic [2:0] ADDR_HALTED    = 3'd6;
    localparam logic [2:0] ADDR_ID        = 3'd7;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_ABORT   = 1;
    localparam int unsigned CTRL_IRQ_CLR = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_TIMEOUT = 2;
    localparam int unsigned STAT_ABORTED = 3;
    localparam int unsigned STAT_W       = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [31:0] ID_VALUE = 32'h4D434350;

endpackage

// File: rtl/videocard_launch_ctrl_if.sv
// HPS control-slave register window (3-bit address, registered read data).
interface videocard_launch_ctrl_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic [2:0]       address_control;
    logic [WIDTH-1:0] data_in_control;
    logic             write_control;
    logic             read_control;
    logic [WIDTH-1:0] data_out_control;

    modport master (
        output address_control, data_in_control, write_control, read_control,
        input  data_out_control
    );

    modport slave (
        input  address_control, data_in_control, write_control, read_control,
        output data_out_control
    );
endinterface

// File: rtl/launch_timeout_counter.sv
// Saturating RUN-cycle counter with a "next count hits the limit" compare output.
module launch_timeout_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_match_c
);
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_inc;

    assign w_count_inc = r_count + WIDTH'(1);

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= w_count_inc;
        end
    end

    // A zero limit disables the match; a saturated count wraps w_count_inc to 0 and never matches.
    assign o_match_c = (i_limit != '0) && (w_count_inc == i_limit);
    assign o_count   = r_count;
endmodule

// File: rtl/videocard_launch_ctrl.sv
// Launch sequencer: hands shared RAM to the cores, runs them until halt/abort/timeout, then returns RAM and raises irq.
module videocard_launch_ctrl
    import videocard_pkg::*;
#(
    parameter int unsigned CORES    = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PC_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    videocard_launch_ctrl_if.slave ctrl,
    input  logic [CORES-1:0]      core_halt,
    output logic [CORES-1:0]      core_run,
    output logic                  core_pc_load,
    output logic [PC_WIDTH-1:0]   core_pc_init,
    output logic                  ram_owner_cores,
    output logic                  irq
);
    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_start;
    logic                r_abort;
    logic                r_irq_clr;
    logic [PC_WIDTH-1:0] r_entry_pc;
    logic [CORES-1:0]    r_core_mask;
    logic [WIDTH-1:0]    r_timeout;
    logic [CORES-1:0]    r_halted;
    logic                r_done;
    logic                r_timed_out;
    logic                r_aborted;
    logic                r_irq;
    logic [CORES-1:0]    r_core_run;
    logic                r_pc_load;
    logic [PC_WIDTH-1:0] r_pc_init;
    logic                r_ram_owner;
    logic [WIDTH-1:0]    r_data_out;
    logic [WIDTH-1:0]    w_cycles;
    logic                w_to_match;
    logic                w_busy;
    logic                w_mask_zero;
    logic                w_all_halted;
    logic                w_launch;
    logic [STAT_W-1:0]   w_status;

    assign w_busy       = (r_state != ST_IDLE);
    assign w_mask_zero  = (r_core_mask == '0);
    assign w_all_halted = (r_halted == r_core_mask);
    assign w_launch     = (r_state == ST_IDLE) && r_start && !w_mask_zero;

    launch_timeout_counter #(.WIDTH(WIDTH)) u_cycles (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_clr     (w_launch),
        .i_en      (r_state == ST_RUN),
        .i_limit   (r_timeout),
        .o_count   (w_cycles),
        .o_match_c (w_to_match)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next state; abort and all-halted and timeout all lead to the same one-cycle drain.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_launch) w_next_state = ST_LOAD;
            ST_LOAD:   w_next_state = ST_RUN;
            ST_RUN:    if (r_abort || w_all_halted || w_to_match) w_next_state = ST_FINISH;
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Register writes; CTRL bits are one-cycle pulses, config is frozen while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start     <= 1'b0;
            r_abort     <= 1'b0;
            r_irq_clr   <= 1'b0;
            r_entry_pc  <= '0;
            r_core_mask <= '1;
            r_timeout   <= '0;
        end else begin
            r_start   <= 1'b0;
            r_abort   <= 1'b0;
            r_irq_clr <= 1'b0;
            if (ctrl.write_control) begin
                case (ctrl.address_control)
                    ADDR_CTRL: begin
                        r_start   <= ctrl.data_in_control[CTRL_START];
                        r_abort   <= ctrl.data_in_control[CTRL_ABORT];
                        r_irq_clr <= ctrl.data_in_control[CTRL_IRQ_CLR];
                    end
                    ADDR_ENTRY_PC:  if (!w_busy) r_entry_pc  <= ctrl.data_in_control[PC_WIDTH-1:0];
                    ADDR_CORE_MASK: if (!w_busy) r_core_mask <= ctrl.data_in_control[CORES-1:0];
                    ADDR_TIMEOUT:   if (!w_busy) r_timeout   <= ctrl.data_in_control;
                    default: ;
                endcase
            end
        end
    end

    // Status flags, sticky halts and irq; a finishing launch wins over a same-cycle IRQ_CLR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_halted    <= '0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            r_aborted   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (r_irq_clr) r_irq <= 1'b0;
            if ((r_state == ST_IDLE) && r_start) begin
                r_timed_out <= 1'b0;
                r_aborted   <= 1'b0;
                if (w_mask_zero) begin
                    r_done <= 1'b1;
                    r_irq  <= 1'b1;
                end else begin
                    r_done   <= 1'b0;
                    r_irq    <= 1'b0;
                    r_halted <= '0;
                end
            end
            if (r_state == ST_RUN) begin
                r_halted <= r_halted | (core_halt & r_core_mask);
                if (r_abort)                         r_aborted   <= 1'b1;
                else if (!w_all_halted && w_to_match) r_timed_out <= 1'b1;
            end
            if (r_state == ST_FINISH) begin
                r_done <= 1'b1;
                r_irq  <= 1'b1;
            end
        end
    end

    // Core-side outputs registered from the next state so they line up with the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_core_run  <= '0;
            r_pc_load   <= 1'b0;
            r_pc_init   <= '0;
            r_ram_owner <= 1'b0;
        end else begin
            r_core_run  <= (w_next_state == ST_RUN) ? r_core_mask : '0;
            r_pc_load   <= (w_next_state == ST_LOAD);
            r_ram_owner <= (w_next_state != ST_IDLE);
            if (w_next_state == ST_LOAD) r_pc_init <= r_entry_pc;
        end
    end

    // STATUS word assembly.
    always_comb begin
        w_status               = '0;
        w_status[STAT_BUSY]    = w_busy;
        w_status[STAT_DONE]    = r_done;
        w_status[STAT_TIMEOUT] = r_timed_out;
        w_status[STAT_ABORTED] = r_aborted;
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
        end else if (ctrl.read_control) begin
            case (ctrl.address_control)
                ADDR_STATUS:    r_data_out <= WIDTH'(w_status);
                ADDR_ENTRY_PC:  r_data_out <= WIDTH'(r_entry_pc);
                ADDR_CORE_MASK: r_data_out <= WIDTH'(r_core_mask);
                ADDR_CYCLES:    r_data_out <= w_cycles;
                ADDR_TIMEOUT:   r_data_out <= r_timeout;
                ADDR_HALTED:    r_data_out <= WIDTH'(r_halted);
                ADDR_ID:        r_data_out <= WIDTH'(ID_VALUE);
                default:        r_data_out <= '0;
            endcase
        end
    end

    assign ctrl.data_out_control = r_data_out;
    assign core_run              = r_core_run;
    assign core_pc_load          = r_pc_load;
    assign core_pc_init          = r_pc_init;
    assign ram_owner_cores       = r_ram_owner;
    assign irq                   = r_irq;
endmodule

// File: tb/tb_videocard_launch_ctrl.sv
// Directed self-checking bench for videocard_launch_ctrl.
module tb_videocard_launch_ctrl;
    import videocard_pkg::*;

    localparam int unsigned CORES    = 4;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned PC_WIDTH = 16;

    logic                clk;
    logic                reset_n;
    logic [CORES-1:0]    core_halt;
    logic [CORES-1:0]    core_run;
    logic                core_pc_load;
    logic [PC_WIDTH-1:0] core_pc_init;
    logic                ram_owner_cores;
    logic                irq;

    int n_cmp = 0;
    int n_err = 0;

    videocard_launch_ctrl_if #(.WIDTH(WIDTH)) bus ();

    videocard_launch_ctrl #(
        .CORES(CORES), .WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ctrl            (bus),
        .core_halt       (core_halt),
        .core_run        (core_run),
        .core_pc_load    (core_pc_load),
        .core_pc_init    (core_pc_init),
        .ram_owner_cores (ram_owner_cores),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address_control = a;
        bus.data_in_control = d;
        bus.write_control   = 1'b1;
        @(negedge clk);
        bus.write_control   = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.address_control = a;
        bus.read_control    = 1'b1;
        @(negedge clk);
        bus.read_control    = 1'b0;
        d = bus.data_out_control;
    endtask

    task automatic rd_check(input logic [2:0] a, input string tag, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] rd;
        reset_n             = 1'b0;
        core_halt           = '0;
        bus.address_control = '0;
        bus.data_in_control = '0;
        bus.write_control   = 1'b0;
        bus.read_control    = 1'b0;
        tick();
        tick();
        check("rst_core_run", 32'(core_run), 32'h0);
        check("rst_pc_load", 32'(core_pc_load), 32'h0);
        check("rst_pc_init", 32'(core_pc_init), 32'h0);
        check("rst_ram_owner", 32'(ram_owner_cores), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_data_out", bus.data_out_control, 32'h0);
        reset_n = 1'b1;
        tick();
        rd_check(ADDR_ID, "id", 32'h4D434350);
        rd_check(ADDR_CORE_MASK, "mask_rst", 32'hF);
        rd_check(ADDR_STATUS, "status_rst", 32'h0);
        rd_check(ADDR_ENTRY_PC, "entry_rst", 32'h0);
        rd_check(ADDR_CTRL, "ctrl_read", 32'h0);

        // Launch with mask 0011, core 2 halting early, halts on cores 0/1 in RUN cycle 9.
        bus_write(ADDR_ENTRY_PC, 32'd5);
        bus_write(ADDR_CORE_MASK, 32'h3);
        bus_write(ADDR_CTRL, 32'h1);
        tick();
        check("load_pulse", 32'(core_pc_load), 32'h1);
        check("load_pc", 32'(core_pc_init), 32'd5);
        check("load_ram", 32'(ram_owner_cores), 32'h1);
        check("load_run", 32'(core_run), 32'h0);
        core_halt = 4'b0100;
        tick();
        check("run_mask", 32'(core_run), 32'h3);
        check("run_pulse_end", 32'(core_pc_load), 32'h0);
        bus_write(ADDR_ENTRY_PC, 32'd9);
        rd_check(ADDR_STATUS, "status_busy", 32'h1);
        bus_write(ADDR_CTRL, 32'h1);
        repeat (5) tick();
        core_halt = 4'b0111;
        tick();
        check("run_before_fin", 32'(core_run), 32'h3);
        tick();
        check("fin_run", 32'(core_run), 32'h0);
        check("fin_ram", 32'(ram_owner_cores), 32'h1);
        check("fin_irq", 32'(irq), 32'h0);
        tick();
        check("done_irq", 32'(irq), 32'h1);
        check("done_ram", 32'(ram_owner_cores), 32'h0);
        core_halt = '0;
        rd_check(ADDR_STATUS, "status_done", 32'h2);
        rd_check(ADDR_CYCLES, "cycles_halt", 32'd10);
        rd_check(ADDR_HALTED, "halted", 32'h3);
        rd_check(ADDR_ENTRY_PC, "entry_busy_wr", 32'd5);
        bus_write(ADDR_CTRL, 32'h4);
        tick();
        check("irq_clr", 32'(irq), 32'h0);
        rd_check(ADDR_STATUS, "done_kept", 32'h2);

        // Timeout after 20 RUN cycles with no halts.
        bus_write(ADDR_TIMEOUT, 32'd20);
        bus_write(ADDR_CTRL, 32'h1);
        tick();
        tick();
        check("to_run", 32'(core_run), 32'h3);
        repeat (19) tick();
        check("to_run_last", 32'(core_run), 32'h3);
        tick();
        check("to_fin_run", 32'(core_run), 32'h0);
        check("to_fin_ram", 32'(ram_owner_cores), 32'h1);
        tick();
        check("to_irq", 32'(irq), 32'h1);
        rd_check(ADDR_STATUS, "status_to", 32'h6);
        rd_check(ADDR_CYCLES, "cycles_to", 32'd20);

        // Abort presented together with the final halt; extra START while busy.
        bus_write(ADDR_TIMEOUT, 32'd0);
        bus_write(ADDR_CTRL, 32'h1);
        tick();
        tick();
        bus_write(ADDR_CTRL, 32'h1);
        tick();
        core_halt = 4'b0011;
        bus_write(ADDR_CTRL, 32'h2);
        check("ab_run", 32'(core_run), 32'h3);
        tick();
        check("ab_fin", 32'(core_run), 32'h0);
        tick();
        check("ab_irq", 32'(irq), 32'h1);
        core_halt = '0;
        rd_check(ADDR_STATUS, "status_ab", 32'hA);
        rd_check(ADDR_CYCLES, "cycles_ab", 32'd4);

        // START with an empty mask completes at once; ABORT in IDLE does nothing.
        bus_write(ADDR_CTRL, 32'h4);
        tick();
        check("irq_clr2", 32'(irq), 32'h0);
        bus_write(ADDR_CORE_MASK, 32'h0);
        bus_write(ADDR_CTRL, 32'h1);
        tick();
        check("zm_irq", 32'(irq), 32'h1);
        check("zm_ram", 32'(ram_owner_cores), 32'h0);
        check("zm_pc_load", 32'(core_pc_load), 32'h0);
        bus_read(ADDR_STATUS, rd);
        check("zm_status", rd & 32'h3, 32'h2);
        bus_write(ADDR_CTRL, 32'h2);
        bus_read(ADDR_STATUS, rd);
        check("idle_abort", rd & 32'h8, 32'h0);

        // Reset in the middle of RUN.
        bus_write(ADDR_CORE_MASK, 32'h5);
        bus_write(ADDR_TIMEOUT, 32'd100);
        bus_write(ADDR_CTRL, 32'h1);
        tick();
        tick();
        check("mr_run", 32'(core_run), 32'h5);
        tick();
        reset_n = 1'b0;
        #1;
        check("mr_core_run", 32'(core_run), 32'h0);
        check("mr_ram", 32'(ram_owner_cores), 32'h0);
        check("mr_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_check(ADDR_STATUS, "mr_status", 32'h0);
        rd_check(ADDR_CORE_MASK, "mr_mask", 32'hF);
        rd_check(ADDR_TIMEOUT, "mr_timeout", 32'h0);
        rd_check(ADDR_ENTRY_PC, "mr_entry", 32'h0);
        rd_check(ADDR_CYCLES, "mr_cycles", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/videocard_launch_ctrl.md
# videocard_launch_ctrl

Control-plane sequencer for the videocard compute cores. It sits between the HPS control slave (3-bit register window) and the core array. It latches launch configuration and hands shared RAM ownership from the HPS to the cores. It starts the cores, collects per-core halts and enforces a timeout. It then returns RAM to the HPS and raises a done interrupt.

## Interface
- CORES, default 4: number of compute cores controlled
- WIDTH, default 32: control data width
- PC_WIDTH, default 16: instruction address width
- clk, input, 1: core clock
- reset_n, input, 1: asynchronous active-low reset
- address_control, input, 3: register index
- data_in_control, input, WIDTH: write data
- write_control, input, 1: write strobe, one access per cycle
- read_control, input, 1: read strobe
- data_out_control, output, WIDTH: registered read data
- core_halt, input, CORES: level, core has halted
- core_run, output, CORES: run enable per core
- core_pc_load, output, 1: one-cycle pulse to load core_pc_init
- core_pc_init, output, PC_WIDTH: entry PC for all cores
- ram_owner_cores, output, 1: 1 = cores own shared RAM, 0 = HPS owns it
- irq, output, 1: level, done or timeout pending

## Operation
- Registers:
  - 0 CTRL (W): bit0 START, bit1 ABORT, bit2 IRQ_CLR. All self-clearing. Reads 0.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 timeout, bit3 aborted.
  - 2 ENTRY_PC (RW): reset 0.
  - 3 CORE_MASK (RW, low CORES bits): reset all ones.
  - 4 CYCLES (R): cycles spent in RUN for the last or current launch.
  - 5 TIMEOUT (RW): limit, reset 0. 0 disables the timeout.
  - 6 HALTED (R): sticky halt bits.
  - 7 ID (R): constant 32'h4D434350.
- Writes to 2, 3 and 5 while busy are ignored. Writes to read-only addresses are ignored.
- FSM IDLE → LOAD → RUN → FINISH → IDLE.
  - IDLE: START with CORE_MASK ≠ 0 → LOAD. This clears done, timeout, aborted, HALTED, CYCLES and irq. START with mask 0 sets done immediately and irq=1, with no launch.
  - LOAD: one cycle. ram_owner_cores=1, core_pc_load=1, core_pc_init=ENTRY_PC. Go to RUN.
  - RUN:
    - core_run = CORE_MASK.
    - HALTED |= core_halt & CORE_MASK. When HALTED == CORE_MASK, go to FINISH.
    - CYCLES increments each RUN cycle and saturates at all-ones.
    - If TIMEOUT ≠ 0 and CYCLES+1 == TIMEOUT, set timeout and go to FINISH.
    - ABORT sets aborted and goes to FINISH.
  - FINISH: one cycle. core_run=0, ram_owner_cores still 1 so last writes can drain. Then IDLE with ram_owner_cores=0, done=1, irq=1.
- Priority in a single RUN cycle: ABORT > all-halted > timeout. Only one status flag is set per launch.
- START while busy is ignored. ABORT in IDLE is ignored. IRQ_CLR clears irq only; done stays set.
- busy = state ≠ IDLE.

## Timing
- Reset values: all outputs 0 (data_out_control=0, core_run=0, core_pc_load=0, ram_owner_cores=0, irq=0), FSM in IDLE.
- Register write takes effect the cycle after the write_control edge.
- Read: data_out_control valid one cycle after read_control and held until the next read. Reading STATUS shows the FSM state of the previous cycle.
- START write at edge N: LOAD at N+1, RUN at N+2, first core_run=1 at N+2.
- Last halt sampled at edge M: FINISH at M+1, IDLE/irq/done at M+2.
- Minimum launch is 4 cycles, START to done.
- Reset mid-run: everything returns to reset values asynchronously and RAM goes back to the HPS. Configuration registers revert.

## Structure
- Shared package (videocard_pkg): register address constants, CTRL/STATUS bit indices, FSM state encoding, ID constant.
- One sub-module, launch_timeout_counter: saturating cycle counter with compare-match output.

## Test plan
- Reset, then read ID and CORE_MASK → 32'h4D434350 and 4'b1111. Outputs are 0 during reset.
- ENTRY_PC=5, mask=4'b0011, START; hold core_halt=0 for 10 cycles, then assert bits 0 and 1 → core_pc_load pulse with pc_init=5. CYCLES=10±1, done=1, irq=1, ram_owner_cores=0 two cycles after the halt.
- Mask 4'b0011 with core 2 halting early → core 2 halt is ignored and HALTED reads 4'b0011 at completion.
- TIMEOUT=20, no halts → FINISH after 20 RUN cycles. STATUS = done|timeout, CYCLES=20.
- ABORT on the same cycle as the final halt → aborted set, timeout clear. A second START while busy has no effect.
- reset_n low for one cycle during RUN → core_run=0 and ram_owner_cores=0 immediately. STATUS=0 after release.
